// File: rtl/ising_config_pkg.sv
// Shared GPIO write-path definitions: bit positions of the PS GPIO word, the queued write record and decoder states.
package ising_config;

  localparam int gpio_addr_lsb   = 0;
  localparam int gpio_addr_width = 16;
  localparam int gpio_data_lsb   = 16;
  localparam int gpio_data_width = 8;
  localparam int gpio_w_clk_bit  = 24;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [gpio_data_width-1:0] data;
  } gpio_wr_t;

  typedef enum logic [1:0] {
    WAIT_LOW,
    WAIT_HIGH,
    SETTLE,
    PUSH
  } gpio_dec_state_t;

endpackage

// File: rtl/gpio_write_decoder_fifo.sv
// First-word-fall-through queue for decoded GPIO writes; head is valid whenever empty_o is low.
module gpio_wr_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, rd_ptr_q;
  logic                do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_data_i;
  end

  assign head_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/gpio_write_decoder.sv
// Decodes PS GPIO register writes: synchronise, detect a settled w_clk rise, latch {addr,data}, queue for the consumer.
module gpio_write_decoder
  import ising_config::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int SETTLE_CYCLES   = 4,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [15:0] wr_count
);

  localparam int SYNC_W = gpio_w_clk_bit + 1;
  localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [SYNC_W-1:0]      sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] prime_q;
  logic                   primed, ws;
  logic                   unused_gpio_hi;

  gpio_dec_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_q, push_d;
  gpio_wr_t         push_wr_q, push_wr_d;
  gpio_wr_t         hold_q, head;
  logic [$bits(gpio_wr_t)-1:0] head_bits;
  logic             fifo_full, fifo_empty, pop, accept, drop;
  logic             overflow_q, overflow_d;
  logic [15:0]      wr_count_q, wr_count_d;

  assign unused_gpio_hi = ^gpio_in[31:SYNC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q[0] <= '0;
    else     sync_q[0] <= gpio_in[SYNC_W-1:0];
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q[gi] <= '0;
      else     sync_q[gi] <= sync_q[gi-1];
    end
  end

  // The synchroniser holds reset zeros for SYNC_STAGES cycles; a low seen then is not a real low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prime_q <= '0;
    else     prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign primed = prime_q[SYNC_STAGES-1];
  assign ws     = sync_q[SYNC_STAGES-1][gpio_w_clk_bit];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push_d    = 1'b0;
    push_wr_d = push_wr_q;
    case (state_q)
      WAIT_LOW:  if (primed && !ws) state_d = WAIT_HIGH;
      WAIT_HIGH: if (ws) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (!ws)                    state_d = WAIT_HIGH;
        else if (cnt_q == CNT_LAST) state_d = PUSH;
        else                        cnt_d   = cnt_q + CNT_W'(1);
      end
      PUSH: begin
        push_d         = 1'b1;
        push_wr_d.addr = sync_q[SYNC_STAGES-1][gpio_addr_lsb +: gpio_addr_width];
        push_wr_d.data = sync_q[SYNC_STAGES-1][gpio_data_lsb +: gpio_data_width];
        state_d        = WAIT_LOW;
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LOW;
      cnt_q     <= '0;
      push_q    <= 1'b0;
      push_wr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      push_q    <= push_d;
      push_wr_q <= push_wr_d;
    end
  end

  gpio_wr_fifo #(
    .WIDTH      ($bits(gpio_wr_t)),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (push_wr_q),
    .pop_i       (pop),
    .head_o      (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign head     = gpio_wr_t'(head_bits);
  assign wr_valid = !fifo_empty;
  assign pop      = wr_valid && wr_ready;
  assign accept   = push_q && (!fifo_full || pop);
  assign drop     = push_q && fifo_full && !pop;

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (drop)         overflow_d = 1'b1;
    wr_count_d = accept ? wr_count_q + 16'd1 : wr_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      wr_count_q <= '0;
      hold_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      wr_count_q <= wr_count_d;
      if (pop) hold_q <= head;
    end
  end

  assign wr_addr  = wr_valid ? head.addr : hold_q.addr;
  assign wr_data  = wr_valid ? head.data : hold_q.data;
  assign overflow = overflow_q;
  assign wr_count = wr_count_q;

endmodule
